pll_lock_monitor: RTL and testbench
===================================

# pll_lock_monitor

- Sits between housekeeping and the core clock mux, in the pll_clk domain.
- Measures the PLL frequency against the external pad clock and declares lock only after consecutive in-range windows.
- Drives the clock-source select (ext_clk_sel) and the divider selects (sel, sel2) to the clocking block.
- Falls back to the external clock on a bad measurement, and changes divider values only while the PLL is not the selected source.

## Interface
Parameters:
- REF_CYCLES, 16: ext_clk periods per measurement window.
- CNT_W, 16: width of the pll_clk cycle counter and limits.
- LOCK_WINDOWS, 4: consecutive good windows required to declare lock.
- ACQ_TIMEOUT, 32: windows allowed in ACQUIRE before fault.

Ports:
- pll_clk  in  1  clock; all state is in this domain.
- resetb  in  1  asynchronous, active-low reset.
- ext_clk  in  1  external pad clock, asynchronous; used only as a frequency reference.
- sw_pll_req  in  1  housekeeping request to run from PLL, asynchronous level.
- min_count  in  CNT_W  lowest acceptable window count, quasi-static.
- max_count  in  CNT_W  highest acceptable window count, quasi-static.
- sel_req  in  3  requested core divider.
- sel2_req  in  3  requested user divider.
- ext_clk_sel  out  1  1 = external clock, 0 = PLL; driven from a dedicated flop.
- sel  out  3  core divider select.
- sel2  out  3  user divider select.
- locked  out  1  state is LOCKED.
- pll_fault  out  1  state is FAULT.
- meas_count  out  CNT_W  last completed window count.
- meas_valid  out  1  one-cycle pulse when meas_count updates.

## Operation
Reference tick:
- ext_clk goes through a 2-FF synchronizer plus a third flop.
- tick = s2 & ~s3: one cycle per ext_clk rising edge.

Measurement:
- Windows run back to back; the tick that closes a window opens the next one.
- The first tick after reset opens the first window.
- cyc_cnt clears on the opening tick and increments every cycle, saturating at all-ones.
- A window closes on the REF_CYCLES-th tick after it opened. At close:
  - meas_count = number of pll_clk cycles after the opening tick, up to and including the closing tick cycle. For an ext_clk period of P pll cycles this is REF_CYCLES*P.
  - meas_valid pulses.
- Forced close: if cyc_cnt saturates (ext_clk stalled or PLL far too fast), the window closes with meas_count = all-ones, and the next tick opens a fresh window.
- Good window: min_count <= meas_count <= max_count, unsigned. Anything else is bad.
- Restart: on entry to ACQUIRE, the window in progress is aborted with no meas_valid, and a fresh window opens at the next tick.

State machine (reset → EXT):
- EXT: ext_clk_sel=1.
  - sw_pll_req_sync=1 → ACQUIRE; clears good_cnt and win_cnt.
- ACQUIRE: ext_clk_sel=1.
  - Each completed window increments win_cnt.
  - A good window increments good_cnt; a bad window clears it.
  - good_cnt reaches LOCK_WINDOWS → LOCKED.
  - Otherwise, win_cnt reaches ACQ_TIMEOUT → FAULT.
  - sw_pll_req_sync=0 → EXT; this has priority over all other transitions.
- LOCKED: ext_clk_sel=0, locked=1.
  - Any bad window → FAULT.
  - sw_pll_req_sync=0 → EXT.
- FAULT: ext_clk_sel=1, pll_fault=1.
  - Exits only when sw_pll_req_sync=0 → EXT.
  - A new request must return to EXT first.

Divider selects:
- sel and sel2 register sel_req and sel2_req every cycle while the registered ext_clk_sel=1.
- They are frozen while ext_clk_sel=0.

Reset values:
- ext_clk_sel=1.
- locked=0, pll_fault=0.
- sel=0, sel2=0.
- meas_count=0, meas_valid=0.
- cyc_cnt, window tick count, good_cnt and win_cnt all 0.
- Synchronizers 0.
- Reset mid-window discards the window.

## Timing
- ext_clk rising edge → tick: 3 pll_clk edges.
- sw_pll_req → sw_pll_req_sync: 2 cycles. State changes on the next edge.
- Closing tick:
  - meas_count and meas_valid are registered on the closing tick edge, visible the following cycle.
  - The state transition caused by that window is on that same edge.
- ext_clk_sel, locked and pll_fault change on the same edge as the state register; no combinational decode glitches.
- Leaving LOCKED on a bad window:
  - ext_clk_sel rises one cycle after the closing tick.
  - sel and sel2 resume tracking one cycle later.
- Loss of pll_clk itself is not detected; the block freezes with it.

## Test plan
Common setup: REF_CYCLES=16, LOCK_WINDOWS=4, min_count=60, max_count=68.
- Reset: hold resetb=0 with random inputs → ext_clk_sel=1, locked=0, pll_fault=0, sel=0, sel2=0, meas_count=0, meas_valid=0.
- Lock:
  - ext_clk period = 4 pll_clk, sw_pll_req=1.
  - → meas_valid every 64 cycles with meas_count=64.
  - → locked=1 and ext_clk_sel=0 together, after the 4th full window following restart.
- Intermittent: window counts 64, 64, 80, 64, 64, 64, 64 → locked rises only after the 7th window; good_cnt clears at 80.
- Loss in LOCKED:
  - From LOCKED, change ext_clk period to 5 → meas_count=80, FAULT, ext_clk_sel=1, pll_fault=1.
  - Holds while req=1.
  - req=0 → EXT and pll_fault=0 three cycles later.
- Timeout and stall:
  - Period 5 forever → FAULT after 32 windows.
  - Separately, with CNT_W=8, stop ext_clk → forced close with meas_count=255 and a bad window.
- Divider freeze: change sel_req from 1 to 3 while LOCKED → sel stays 1; after fault or release, sel=3 within 1 cycle of ext_clk_sel=1.

Source files
------------

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: measures pll_clk against ext_clk over fixed reference windows,
// declares lock after consecutive in-range windows and steers clock source/divider selects.
module pll_lock_monitor #(
    parameter int REF_CYCLES   = 16,
    parameter int CNT_W        = 16,
    parameter int LOCK_WINDOWS = 4,
    parameter int ACQ_TIMEOUT  = 32
) (
    input  logic             pll_clk,
    input  logic             resetb,
    input  logic             ext_clk,
    input  logic             sw_pll_req,
    input  logic [CNT_W-1:0] min_count,
    input  logic [CNT_W-1:0] max_count,
    input  logic [2:0]       sel_req,
    input  logic [2:0]       sel2_req,
    output logic             ext_clk_sel,
    output logic [2:0]       sel,
    output logic [2:0]       sel2,
    output logic             locked,
    output logic             pll_fault,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid
);

    localparam int TW = $clog2(REF_CYCLES + 1);
    localparam int GW = $clog2(LOCK_WINDOWS + 1);
    localparam int WW = $clog2(ACQ_TIMEOUT + 1);

    typedef enum logic [1:0] {S_EXT, S_ACQ, S_LOCKED, S_FAULT} state_t;

    state_t state, state_nxt;

    logic ext_s1, ext_s2, ext_s3, tick;
    logic req_s1, req_sync;

    logic             win_open;
    logic [TW-1:0]    tick_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic             cyc_sat, close_tick, win_close, win_good, restart;
    logic [CNT_W-1:0] win_count;

    logic [GW-1:0] good_cnt;
    logic [WW-1:0] win_cnt;
    logic          ext_sel_nxt, locked_nxt, fault_nxt;

    always_ff @(posedge pll_clk or negedge resetb) begin
        if (!resetb) begin
            ext_s1   <= 1'b0;
            ext_s2   <= 1'b0;
            ext_s3   <= 1'b0;
            req_s1   <= 1'b0;
            req_sync <= 1'b0;
        end else begin
            ext_s1   <= ext_clk;
            ext_s2   <= ext_s1;
            ext_s3   <= ext_s2;
            req_s1   <= sw_pll_req;
            req_sync <= req_s1;
        end
    end

    assign tick = ext_s2 & ~ext_s3;

    // Entering ACQUIRE throws away whatever window was in progress.
    assign restart    = (state == S_EXT) && req_sync;
    assign cyc_sat    = win_open && (cyc_cnt == '1);
    assign close_tick = win_open && tick && (tick_cnt == TW'(REF_CYCLES - 1));
    assign win_close  = !restart && (cyc_sat || close_tick);
    assign win_count  = cyc_sat ? '1 : cyc_cnt + CNT_W'(1);
    assign win_good   = (win_count >= min_count) && (win_count <= max_count);

    always_ff @(posedge pll_clk or negedge resetb) begin
        if (!resetb) begin
            win_open   <= 1'b0;
            tick_cnt   <= '0;
            cyc_cnt    <= '0;
            meas_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= win_close;
            if (win_close)
                meas_count <= win_count;
            if (restart) begin
                win_open <= 1'b0;
            end else if (tick && (!win_open || close_tick)) begin
                // the closing tick doubles as the opening tick of the next window
                win_open <= 1'b1;
                tick_cnt <= '0;
                cyc_cnt  <= '0;
            end else if (cyc_sat) begin
                win_open <= 1'b0;
            end else if (win_open) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
                if (tick)
                    tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge pll_clk or negedge resetb) begin
        if (!resetb) begin
            state       <= S_EXT;
            good_cnt    <= '0;
            win_cnt     <= '0;
            ext_clk_sel <= 1'b1;
            locked      <= 1'b0;
            pll_fault   <= 1'b0;
        end else begin
            state       <= state_nxt;
            ext_clk_sel <= ext_sel_nxt;
            locked      <= locked_nxt;
            pll_fault   <= fault_nxt;
            if (restart) begin
                good_cnt <= '0;
                win_cnt  <= '0;
            end else if ((state == S_ACQ) && win_close) begin
                win_cnt  <= win_cnt + WW'(1);
                good_cnt <= win_good ? good_cnt + GW'(1) : '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EXT: begin
                if (req_sync)
                    state_nxt = S_ACQ;
            end
            S_ACQ: begin
                if (!req_sync)
                    state_nxt = S_EXT;
                else if (win_close) begin
                    if (win_good && (good_cnt == GW'(LOCK_WINDOWS - 1)))
                        state_nxt = S_LOCKED;
                    else if (win_cnt == WW'(ACQ_TIMEOUT - 1))
                        state_nxt = S_FAULT;
                end
            end
            S_LOCKED: begin
                if (!req_sync)
                    state_nxt = S_EXT;
                else if (win_close && !win_good)
                    state_nxt = S_FAULT;
            end
            S_FAULT: begin
                if (!req_sync)
                    state_nxt = S_EXT;
            end
            default: state_nxt = S_EXT;
        endcase
    end

    // Outputs decoded from the next state and registered alongside it, so they never glitch.
    always_comb begin
        ext_sel_nxt = (state_nxt != S_LOCKED);
        locked_nxt  = (state_nxt == S_LOCKED);
        fault_nxt   = (state_nxt == S_FAULT);
    end

    always_ff @(posedge pll_clk or negedge resetb) begin
        if (!resetb) begin
            sel  <= 3'd0;
            sel2 <= 3'd0;
        end else if (ext_clk_sel) begin
            sel  <= sel_req;
            sel2 <= sel2_req;
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: per-window ext_clk periods feed a sequence-level model
// that predicts window counts, lock/fault window indices and divider freezing.
module tb_pll_lock_monitor;

    localparam int REF   = 16;
    localparam int LOCKW = 4;
    localparam int TMO   = 32;

    logic        pll_clk = 1'b0;
    logic        resetb  = 1'b0;
    logic        ext_clk;
    logic        sw_pll_req = 1'b0;
    logic [2:0]  sel_req  = 3'd0;
    logic [2:0]  sel2_req = 3'd0;

    logic        ext_clk_sel, locked, pll_fault, meas_valid;
    logic [2:0]  sel, sel2;
    logic [15:0] meas_count;

    logic        ext_clk_sel8, locked8, pll_fault8, meas_valid8;
    logic [2:0]  sel8, sel28;
    logic [7:0]  meas_count8;

    int checks = 0;
    int errors = 0;
    int ed_q[$];
    int win_p[$];
    int gap = -1;
    int hi  = 0;

    always #5 pll_clk = ~pll_clk;

    pll_lock_monitor #(.REF_CYCLES(REF), .CNT_W(16), .LOCK_WINDOWS(LOCKW), .ACQ_TIMEOUT(TMO)) dut (
        .pll_clk(pll_clk), .resetb(resetb), .ext_clk(ext_clk), .sw_pll_req(sw_pll_req),
        .min_count(16'd60), .max_count(16'd68), .sel_req(sel_req), .sel2_req(sel2_req),
        .ext_clk_sel(ext_clk_sel), .sel(sel), .sel2(sel2), .locked(locked),
        .pll_fault(pll_fault), .meas_count(meas_count), .meas_valid(meas_valid));

    pll_lock_monitor #(.REF_CYCLES(REF), .CNT_W(8), .LOCK_WINDOWS(LOCKW), .ACQ_TIMEOUT(TMO)) dut8 (
        .pll_clk(pll_clk), .resetb(resetb), .ext_clk(ext_clk), .sw_pll_req(sw_pll_req),
        .min_count(8'd60), .max_count(8'd68), .sel_req(sel_req), .sel2_req(sel2_req),
        .ext_clk_sel(ext_clk_sel8), .sel(sel8), .sel2(sel28), .locked(locked8),
        .pll_fault(pll_fault8), .meas_count(meas_count8), .meas_valid(meas_valid8));

    // ext_clk: each queued gap is the pll_clk distance to the next rising edge; empty queue = stall
    initial begin
        ext_clk = 1'b0;
        forever begin
            @(negedge pll_clk);
            if (hi > 0) begin
                hi--;
                if (hi == 0) ext_clk = 1'b0;
            end
            if (gap < 0 && ed_q.size() > 0) gap = ed_q.pop_front();
            if (gap > 0) gap--;
            if (gap == 0) begin
                ext_clk = 1'b1;
                hi  = 2;
                gap = -1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit good_p(input int p);
        return (REF * p >= 60) && (REF * p <= 68);
    endfunction

    // Lock = first window closing LOCKW consecutive good windows within the timeout;
    // fault = timeout without lock, or the first bad window after lock.
    function automatic void outcome(output int lock_at, output int fault_at);
        int n = win_p.size();
        int lim = (n < TMO) ? n : TMO;
        lock_at  = 0;
        fault_at = 0;
        for (int w = LOCKW; w <= lim && lock_at == 0; w++) begin
            bit all_good = 1'b1;
            for (int k = w - LOCKW; k < w; k++)
                if (!good_p(win_p[k])) all_good = 1'b0;
            if (all_good) lock_at = w;
        end
        if (lock_at == 0) begin
            if (n >= TMO) fault_at = TMO;
        end else begin
            for (int w = lock_at + 1; w <= n && fault_at == 0; w++)
                if (!good_p(win_p[w-1])) fault_at = w;
        end
    endfunction

    task automatic run_windows(input string tag, output bit lk, output bit ft);
        int lock_at, fault_at;
        bit got, was_lk;
        logic [2:0] frozen, frozen2, nv, nv2;
        was_lk  = 1'b0;
        frozen  = sel_req;
        frozen2 = sel2_req;
        lk = 1'b0;
        ft = 1'b0;
        outcome(lock_at, fault_at);
        ed_q.push_back(1);
        foreach (win_p[i])
            for (int k = 0; k < REF; k++) ed_q.push_back(win_p[i]);
        for (int w = 1; w <= win_p.size(); w++) begin
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge pll_clk);
                got = meas_valid;
            end
            chk({tag, "_valid"}, 32'(got), 32'd1);
            if (!got) break;
            chk({tag, "_count"}, 32'(meas_count), 32'(REF * win_p[w-1]));
            lk = (lock_at != 0) && (w >= lock_at) && !((fault_at != 0) && (w >= fault_at));
            ft = (fault_at != 0) && (w >= fault_at);
            chk({tag, "_locked"}, 32'(locked), 32'(lk));
            chk({tag, "_fault"}, 32'(pll_fault), 32'(ft));
            chk({tag, "_extsel"}, 32'(ext_clk_sel), 32'(!lk));
            if (lk && !was_lk) begin
                frozen  = sel_req;
                frozen2 = sel2_req;
            end
            was_lk = lk;
            nv  = 3'($urandom_range(7));
            nv2 = 3'($urandom_range(7));
            sel_req  = nv;
            sel2_req = nv2;
            @(negedge pll_clk);
            chk({tag, "_sel"}, 32'(sel), 32'(lk ? frozen : nv));
            chk({tag, "_sel2"}, 32'(sel2), 32'(lk ? frozen2 : nv2));
        end
    endtask

    // Drop the request (checking the 3-cycle exit), then re-request to restart acquisition.
    task automatic restart(input bit was_lk, input bit was_ft);
        logic [2:0] nv;
        @(negedge pll_clk);
        sw_pll_req = 1'b0;
        repeat (2) @(negedge pll_clk);
        chk("rel_hold_locked", 32'(locked), 32'(was_lk));
        chk("rel_hold_fault", 32'(pll_fault), 32'(was_ft));
        @(negedge pll_clk);
        chk("rel_locked", 32'(locked), 32'd0);
        chk("rel_fault", 32'(pll_fault), 32'd0);
        chk("rel_extsel", 32'(ext_clk_sel), 32'd1);
        nv = 3'($urandom_range(7));
        sel_req = nv;
        @(negedge pll_clk);
        chk("ext_sel_track", 32'(sel), 32'(nv));
        sw_pll_req = 1'b1;
        repeat (6) @(negedge pll_clk);
        chk("acq_locked", 32'(locked), 32'd0);
        chk("acq_extsel", 32'(ext_clk_sel), 32'd1);
    endtask

    initial begin
        bit lk, ft, got, main_seen;
        int n, r;

        // reset with random inputs, including a running ext_clk
        for (int i = 0; i < 12; i++) ed_q.push_back(int'($urandom_range(3, 7)));
        for (int i = 0; i < 3; i++) begin
            sw_pll_req = 1'($urandom_range(1));
            sel_req    = 3'($urandom_range(7));
            sel2_req   = 3'($urandom_range(7));
            repeat (5) @(negedge pll_clk);
            chk("rst_extsel", 32'(ext_clk_sel), 32'd1);
            chk("rst_locked", 32'(locked), 32'd0);
            chk("rst_fault", 32'(pll_fault), 32'd0);
            chk("rst_sel", 32'(sel), 32'd0);
            chk("rst_sel2", 32'(sel2), 32'd0);
            chk("rst_count", 32'(meas_count), 32'd0);
            chk("rst_valid", 32'(meas_valid), 32'd0);
            chk("rst_count8", 32'(meas_count8), 32'd0);
        end
        sw_pll_req = 1'b0;
        ed_q.delete();
        repeat (20) @(negedge pll_clk);
        resetb = 1'b1;
        repeat (3) @(negedge pll_clk);

        // intermittent lock, then loss in LOCKED, then FAULT holds while requested
        restart(1'b0, 1'b0);
        win_p = '{4, 4, 5, 4, 4, 4, 4, 4, 5, 4, 4};
        run_windows("intermit", lk, ft);
        restart(lk, ft);

        // straight lock, then ext_clk stalls: narrow counter saturates into a bad window
        win_p = '{4, 4, 4, 4, 4};
        run_windows("lock", lk, ft);
        got = 1'b0;
        main_seen = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge pll_clk);
            got = meas_valid8;
            if (meas_valid) main_seen = 1'b1;
        end
        chk("stall_valid8", 32'(got), 32'd1);
        chk("stall_count8", 32'(meas_count8), 32'd255);
        chk("stall_fault8", 32'(pll_fault8), 32'd1);
        chk("stall_locked8", 32'(locked8), 32'd0);
        chk("stall_extsel8", 32'(ext_clk_sel8), 32'd1);
        chk("stall_main_quiet", 32'(main_seen), 32'd0);
        chk("stall_main_locked", 32'(locked), 32'd1);
        restart(lk, ft);

        // acquisition timeout
        win_p.delete();
        for (int i = 0; i < TMO + 1; i++) win_p.push_back(5);
        run_windows("timeout", lk, ft);
        restart(lk, ft);

        // random window sequences
        for (int s = 0; s < 3; s++) begin
            win_p.delete();
            n = int'($urandom_range(10, 36));
            for (int i = 0; i < n; i++) begin
                r = int'($urandom_range(9));
                win_p.push_back((r < 6) ? 4 : (r < 8) ? 5 : 3);
            end
            run_windows("random", lk, ft);
            restart(lk, ft);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
